matrix_alu_engine: RTL
======================

Name: matrix_alu_engine

Overview:
- Datapath responder to the coprocessor control FSM.
- On a start_calc pulse it walks all DIM*DIM elements of matrices A and B held in shared data memory. It computes the element-wise sum, difference or opposite selected by sel_operacao and writes each result to matrix C.
- It raises a one-cycle done pulse when finished, so the controller's WAIT_CALC state can wait on it.
- It sits between the control FSM and the single-port synchronous matrix memory.

Parameters:
- DATA_W, 8, element width, signed two's complement.
- DIM, 5, matrix dimension; DIM*DIM elements per matrix.
- ADDR_W, 7, memory address width.
- BASE_A, 0, word address of element 0 of A.
- BASE_B, 25, word address of element 0 of B.
- BASE_C, 50, word address of element 0 of C.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_calc  in  1  one-cycle request pulse from the control FSM.
- sel_operacao  in  2  00 add (A+B), 01 sub (A-B), 10 opposite (-A), 11 invalid.
- mem_addr  out  ADDR_W  memory word address.
- mem_re  out  1  read enable; data returns on mem_rdata the next cycle.
- mem_rdata  in  DATA_W  read data.
- mem_we  out  1  write enable, written at the rising edge.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  high while a matrix operation is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for an invalid operation.
- overflow  out  1  sticky signed-overflow flag for the last operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, idx=0.
  - mem_re, mem_we, busy, done, err and overflow are all 0.
  - mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts immediately. No further write occurs; writes already performed remain in memory.
- States: IDLE, RD_A, RD_B, CALC, WR_C, FIN. FIN is the done state.
- IDLE:
  - start_calc=1 latches sel_operacao into op, clears overflow and sets idx=0.
  - Next state is RD_A, or FIN if op=11.
  - start_calc outside IDLE is ignored; op stays frozen.
- RD_A: mem_re=1, mem_addr=BASE_A+idx. Next state is RD_B for add/sub, CALC for opposite.
- RD_B: mem_re=1, mem_addr=BASE_B+idx, a_reg<=mem_rdata (A data). Next state CALC.
- CALC:
  - Operand A is a_reg for add/sub and mem_rdata for opposite.
  - Operand B is mem_rdata.
  - Result is registered into res_reg; overflow is ORed with the element's overflow bit. Next state WR_C.
- WR_C:
  - mem_we=1, mem_addr=BASE_C+idx, mem_wdata=res_reg.
  - If idx==DIM*DIM-1, next state FIN; else idx<=idx+1 and next state RD_A.
- FIN:
  - done=1 for one cycle; err=1 for one cycle if op=11. Next state IDLE.
  - A start_calc presented during FIN is ignored.
- busy=1 in RD_A, RD_B, CALC and WR_C; busy=0 in IDLE and FIN.
- mem_re and mem_we are never asserted together; mem_addr=0 when neither is asserted.
- Arithmetic:
  - Results are modulo 2^DATA_W (wrap, no saturation).
  - Add overflow: operands of equal sign with a result of different sign.
  - Sub overflow: operands of different sign with result sign different from A.
  - Opposite overflow: A = -2^(DATA_W-1) (result equals A).
- Latency, from the clk edge sampling start_calc to done high:
  - add/sub: 4*DIM*DIM+1 cycles (101 at default).
  - opposite: 3*DIM*DIM+1 cycles (76 at default).
  - invalid: 1 cycle.
- overflow holds its value after FIN until the next accepted start_calc.

Test Plan:
- Add: A[i]=i, B[i]=2i for i=0..24, start_calc with sel=00 -> C[i]=3i for all i. done high exactly 101 cycles after the start edge; busy high for 100 cycles; overflow=0; err=0.
- Sub overflow: A[0]=0x80, B[0]=0x01, others 0, sel=01 -> C[0]=0x7F and overflow=1 at done, holding until the next start. Then rerun with A[0]=0x05, B[0]=0x03 -> C[0]=0x02 and overflow cleared to 0.
- Opposite: A[i]=0x05, plus A[3]=0x80, sel=10 -> C[i]=0xFB, C[3]=0x80, overflow=1. mem_addr is never in 25..49 while mem_re=1; done 76 cycles after start.
- Invalid: sel=11 -> no mem_re or mem_we ever asserted. done=1 and err=1 together for one cycle, one cycle after the start edge; busy stays 0.
- Busy start: during an add, pulse start_calc with sel=10 at cycle 40 -> ignored. Results remain A+B and done arrives at cycle 101, once only.
- Reset mid-op: assert reset at cycle 50 of an add -> all outputs 0 asynchronously. C[0..11] are written; C[12..24] keep their pre-test contents. A fresh start completes normally.

Source files
------------

// File: rtl/matrix_alu_engine.sv
// ============================================================================
//  Module   : matrix_alu_engine
//  Function : Element-wise add / subtract / negate over two DIM x DIM signed
//             matrices held in a single-port synchronous memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_alu_engine #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5,
  parameter int ADDR_W = 7,
  parameter int BASE_A = 0,
  parameter int BASE_B = 25,
  parameter int BASE_C = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_calc,
  input  logic [1:0]        sel_operacao,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow
);

  localparam int c_NELEM = DIM * DIM;
  localparam int c_IDX_W = (c_NELEM > 1) ? $clog2(c_NELEM) : 1;
  localparam int c_MSB   = DATA_W - 1;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_NEG = 2'b10;
  localparam logic [1:0] c_OP_INV = 2'b11;

  localparam logic [DATA_W-1:0] c_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] c_ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_CALC = 3'd3,
    S_WR_C = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [c_IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                done_q, err_q;

  logic [DATA_W-1:0]   w_opa, w_opb, w_res;
  logic                w_ovf;
  logic                w_last;

  assign w_last = (idx_q == c_IDX_W'(c_NELEM - 1));

  // Negate has no B read, so its A operand arrives straight from memory in CALC.
  always_comb begin
    w_opa = (op_q == c_OP_NEG) ? mem_rdata : a_q;
    w_opb = mem_rdata;
    w_res = '0;
    w_ovf = 1'b0;
    case (op_q)
      c_OP_ADD: begin
        w_res = w_opa + w_opb;
        w_ovf = (w_opa[c_MSB] == w_opb[c_MSB]) && (w_res[c_MSB] != w_opa[c_MSB]);
      end
      c_OP_SUB: begin
        w_res = w_opa - w_opb;
        w_ovf = (w_opa[c_MSB] != w_opb[c_MSB]) && (w_res[c_MSB] != w_opa[c_MSB]);
      end
      c_OP_NEG: begin
        w_res = (~w_opa) + c_ONE;
        w_ovf = (w_opa == c_MOST_NEG);
      end
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    a_d       = a_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_calc) begin
          op_d    = sel_operacao;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = (sel_operacao == c_OP_INV) ? S_FIN : S_RD_A;
        end
      end
      S_RD_A: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = ADDR_W'(BASE_A) + ADDR_W'(idx_q);
        state_d  = (op_q == c_OP_NEG) ? S_CALC : S_RD_B;
      end
      S_RD_B: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = ADDR_W'(BASE_B) + ADDR_W'(idx_q);
        a_d      = mem_rdata;
        state_d  = S_CALC;
      end
      S_CALC: begin
        busy    = 1'b1;
        res_d   = w_res;
        ovf_d   = ovf_q | w_ovf;
        state_d = S_WR_C;
      end
      S_WR_C: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(BASE_C) + ADDR_W'(idx_q);
        mem_wdata = res_q;
        if (w_last) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + c_IDX_W'(1);
          state_d = S_RD_A;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // done/err are registered off FIN so they land one cycle after entering it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= c_OP_ADD;
      a_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= (state_q == S_FIN);
      err_q   <= (state_q == S_FIN) && (op_q == c_OP_INV);
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire
